// File: rtl/imem_ctrl.sv
// imem_ctrl: sequencer/arbiter in front of a single-port, sync-read instruction memory.
// After reset it zero-fills the array. It then takes a program image from the boot loader
// and serves core fetches with 1-cycle latency. A new load can be requested from RUN.
// Optional feature macro: IMEM_ALIGN_CHECK_EN. When it is defined, misaligned fetches
// return a flagged NOP instead of reading memory.
module imem_ctrl #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_load_start,
   input  logic              i_load_valid,
   input  logic [31:0]       i_load_data,
   input  logic              i_load_last,
   output logic              o_load_ready,
   output logic              o_boot_done,
   input  logic              i_fetch_req,
   input  logic [31:0]       i_fetch_addr,
   output logic              o_fetch_valid,
   output logic [31:0]       o_fetch_instr,
   output logic              o_fetch_stall,
   output logic              o_fetch_err,
   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [31:0]       o_mem_wdata,
   input  logic [31:0]       i_mem_rdata
);

   localparam logic [1:0] S_CLEAR = 2'd0;
   localparam logic [1:0] S_IDLE  = 2'd1;
   localparam logic [1:0] S_LOAD  = 2'd2;
   localparam logic [1:0] S_RUN   = 2'd3;

   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);
   localparam logic [31:0]       NOP       = 32'h0000_0013;

   logic [1:0]        state, state_n;
   logic [ADDR_W-1:0] cnt, cnt_n;
   logic              load_acc;   // loader word written this cycle
   logic              fetch_go;   // fetch accepted (load request has priority)
   logic              fetch_mis;  // accepted fetch is misaligned
   logic              fetch_rd;   // accepted fetch that actually reads memory
   logic [31:0]       instr_q;    // last presented instruction, held between valids
   logic              unused_addr;

   // Only the word-index bits of the PC select a memory word; the rest wrap away.
   assign unused_addr = ^{i_fetch_addr[31:ADDR_W+2], i_fetch_addr[1:0]};

   assign load_acc = (state == S_LOAD) && i_load_valid;
   assign fetch_go = (state == S_RUN) && i_fetch_req && !i_load_start;
`ifdef IMEM_ALIGN_CHECK_EN
   assign fetch_mis = (i_fetch_addr[1:0] != 2'b00);
`else
   assign fetch_mis = 1'b0;
`endif
   assign fetch_rd = fetch_go && !fetch_mis;

   // Next state / word counter for the clear, load and run sequence
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         S_CLEAR: begin
            cnt_n = cnt + 1'b1;
            if (cnt == LAST_WORD) begin
               cnt_n   = '0;
               state_n = S_IDLE;
            end
         end
         S_IDLE: begin
            if (i_load_start) begin
               cnt_n   = '0;
               state_n = S_LOAD;
            end
         end
         S_LOAD: begin
            if (load_acc) begin
               cnt_n = cnt + 1'b1;
               // A full array ends the image even without last; never wrap over word 0.
               if (i_load_last || cnt == LAST_WORD) begin
                  cnt_n   = '0;
                  state_n = S_RUN;
               end
            end
         end
         default: begin
            if (i_load_start) begin
               cnt_n   = '0;
               state_n = S_LOAD;
            end
         end
      endcase
   end

   // Memory port drive; gated by reset so an aborted cycle never touches the array
   always_comb begin
      o_mem_en    = 1'b0;
      o_mem_we    = 1'b0;
      o_mem_addr  = cnt;
      o_mem_wdata = '0;
      if (i_rst) begin
         if (state == S_CLEAR) begin
            o_mem_en = 1'b1;
            o_mem_we = 1'b1;
         end else if (load_acc) begin
            o_mem_en    = 1'b1;
            o_mem_we    = 1'b1;
            o_mem_wdata = i_load_data;
         end else if (fetch_rd) begin
            o_mem_en   = 1'b1;
            o_mem_addr = i_fetch_addr[ADDR_W+1:2];
         end
      end
   end

   // State, counter and registered status/fetch outputs
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state         <= S_CLEAR;
         cnt           <= '0;
         o_load_ready  <= 1'b0;
         o_boot_done   <= 1'b0;
         o_fetch_stall <= 1'b1;
         o_fetch_valid <= 1'b0;
         instr_q       <= '0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         o_load_ready  <= (state_n == S_LOAD);
         o_boot_done   <= (state_n == S_RUN);
         o_fetch_stall <= (state_n != S_RUN);
         o_fetch_valid <= fetch_go;
         instr_q       <= o_fetch_instr;
      end
   end

`ifdef IMEM_ALIGN_CHECK_EN
   logic err_q;

   // Remember that the returning fetch was misaligned so it yields a NOP
   always_ff @(posedge i_clk) begin
      if (!i_rst) err_q <= 1'b0;
      else        err_q <= fetch_go && fetch_mis;
   end

   assign o_fetch_err   = err_q;
   assign o_fetch_instr = !o_fetch_valid ? instr_q : (err_q ? NOP : i_mem_rdata);
`else
   assign o_fetch_err   = 1'b0;
   assign o_fetch_instr = o_fetch_valid ? i_mem_rdata : instr_q;
`endif

endmodule

// File: tb/tb_imem_ctrl.sv
// Self-checking bench for imem_ctrl: sync-read memory model plus a word-array reference image.
module tb_imem_ctrl;
   localparam int          DEPTH = 64;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
   logic [31:0] load_data = '0;
   logic        load_ready, boot_done;
   logic        fetch_req = 1'b0;
   logic [31:0] fetch_addr = '0;
   logic        fetch_valid, fetch_stall, fetch_err;
   logic [31:0] fetch_instr;
   logic        mem_en, mem_we;
   logic [5:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;

   logic [31:0] mem     [DEPTH];
   logic [31:0] ref_mem [DEPTH];
   logic [31:0] last_instr = '0;
   int checks = 0;
   int errors = 0;

   imem_ctrl #(.DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_load_start(load_start), .i_load_valid(load_valid), .i_load_data(load_data),
      .i_load_last(load_last), .o_load_ready(load_ready), .o_boot_done(boot_done),
      .i_fetch_req(fetch_req), .i_fetch_addr(fetch_addr), .o_fetch_valid(fetch_valid),
      .o_fetch_instr(fetch_instr), .o_fetch_stall(fetch_stall), .o_fetch_err(fetch_err),
      .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Single-port sync-read memory array
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [5:0] word_of(input logic [31:0] pc);
      return 6'((pc >> 2) % DEPTH);
   endfunction

   // Load n random words (last flagged on word n-1 if use_last); assumes IDLE or RUN on entry
   task automatic do_load(input int n, input bit use_last);
      bit done = 0;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < n; i++) begin
         load_valid = 1'b1;
         load_data  = $urandom;
         load_last  = use_last && (i == n - 1);
         #1;
         checks++;
         if (load_ready !== !done) begin
            errors++; $display("FAIL load_ready word %0d got %b exp %b", i, load_ready, !done);
         end
         checks++;
         if (!done && (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 6'(i) || mem_wdata !== load_data)) begin
            errors++; $display("FAIL load_write word %0d got en=%b we=%b a=%0d d=%h exp a=%0d d=%h",
                               i, mem_en, mem_we, mem_addr, mem_wdata, i, load_data);
         end else if (done && mem_en !== 1'b0) begin
            errors++; $display("FAIL load_extra word %0d got mem_en=%b exp 0", i, mem_en);
         end
         if (!done) begin
            ref_mem[i] = load_data;
            done = load_last || (i == DEPTH - 1);
         end
         tick();
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic test_reset;
      int nwr = 0;
      bit bad_wr = 0, bad_stall = 0;
      rst = 1'b0;
      tick(); tick();
      checks++;
      if ({fetch_valid, fetch_instr, boot_done, fetch_err, load_ready, fetch_stall} !== {1'b0, 32'h0, 4'b0001}) begin
         errors++; $display("FAIL reset_outputs got v=%b i=%h bd=%b er=%b lr=%b st=%b exp 0 0 0 0 0 1",
                            fetch_valid, fetch_instr, boot_done, fetch_err, load_ready, fetch_stall);
      end
      rst = 1'b1;
      for (int c = 0; c < 80; c++) begin
         load_start = (c == 10);   // ignored during clear
         #1;
         if (mem_en) begin
            if (mem_we !== 1'b1 || mem_wdata !== 32'h0 || mem_addr !== 6'(nwr)) bad_wr = 1;
            nwr++;
         end
         if (fetch_stall !== 1'b1) bad_stall = 1;
         tick();
      end
      load_start = 1'b0;
      checks++;
      if (nwr != DEPTH || bad_wr) begin
         errors++; $display("FAIL clear_writes got %0d writes (bad=%b) exp %0d zero writes in order", nwr, bad_wr, DEPTH);
      end
      checks++;
      if (bad_stall) begin
         errors++; $display("FAIL clear_stall got stall low exp stall=1 throughout");
      end
      checks++;
      if (load_ready !== 1'b0 || boot_done !== 1'b0) begin
         errors++; $display("FAIL idle_state got lr=%b bd=%b exp 0 0", load_ready, boot_done);
      end
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      last_instr = '0;
   endtask

   task automatic test_load_fetch;
      do_load(3, 1);
      checks++;
      if (boot_done !== 1'b1 || fetch_stall !== 1'b0 || load_ready !== 1'b0) begin
         errors++; $display("FAIL run_entry got bd=%b st=%b lr=%b exp 1 0 0", boot_done, fetch_stall, load_ready);
      end
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            checks++;
            if (fetch_valid !== 1'b1 || fetch_instr !== ref_mem[i-1]) begin
               errors++; $display("FAIL b2b_fetch %0d got v=%b i=%h exp 1 %h", i - 1, fetch_valid, fetch_instr, ref_mem[i-1]);
            end
         end
         fetch_req  = (i < 3);
         fetch_addr = 32'(4 * i);
         #1;
         if (i < 3) begin
            checks++;
            if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 6'(i)) begin
               errors++; $display("FAIL b2b_read %0d got en=%b we=%b a=%0d exp 1 0 %0d", i, mem_en, mem_we, mem_addr, i);
            end
         end
         tick();
      end
      last_instr = ref_mem[2];
      checks++;
      if (fetch_valid !== 1'b0 || fetch_instr !== last_instr) begin
         errors++; $display("FAIL fetch_hold got v=%b i=%h exp 0 %h", fetch_valid, fetch_instr, last_instr);
      end
   endtask

   task automatic test_random_fetch(input int n);
      bit exp_v = 0;
      logic [31:0] exp_w = '0;
      int nbad = 0;
      for (int i = 0; i <= n; i++) begin
         checks++;
         if (fetch_valid !== exp_v || fetch_instr !== (exp_v ? exp_w : last_instr)) begin
            errors++; nbad++;
            if (nbad < 5) $display("FAIL rand_fetch cyc %0d got v=%b i=%h exp %b %h",
                                   i, fetch_valid, fetch_instr, exp_v, exp_v ? exp_w : last_instr);
         end
         if (exp_v) last_instr = exp_w;
         fetch_req  = (i < n) && ($urandom_range(0, 3) != 0);
         fetch_addr = $urandom;
`ifdef IMEM_ALIGN_CHECK_EN
         fetch_addr[1:0] = 2'b00;
`endif
         exp_v = fetch_req;
         exp_w = ref_mem[word_of(fetch_addr)];
         #1;
         if (fetch_req && (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== word_of(fetch_addr))) begin
            checks++; errors++;
            $display("FAIL rand_read cyc %0d got en=%b a=%0d exp 1 %0d", i, mem_en, mem_addr, word_of(fetch_addr));
         end
         tick();
      end
      fetch_req = 1'b0;
   endtask

   task automatic test_full_load;
      do_load(DEPTH + 1, 0);
      checks++;
      if (boot_done !== 1'b1 || load_ready !== 1'b0) begin
         errors++; $display("FAIL full_load_end got bd=%b lr=%b exp 1 0", boot_done, load_ready);
      end
      test_random_fetch(40);
   endtask

   task automatic test_wrap_align;
      fetch_req = 1'b1; fetch_addr = 32'h104;
      tick();
      fetch_req = 1'b0;
      checks++;
      if (fetch_valid !== 1'b1 || fetch_instr !== ref_mem[1] || fetch_err !== 1'b0) begin
         errors++; $display("FAIL pc_wrap got v=%b i=%h e=%b exp 1 %h 0", fetch_valid, fetch_instr, fetch_err, ref_mem[1]);
      end
      last_instr = ref_mem[1];
      fetch_req = 1'b1; fetch_addr = 32'h6;
      #1;
`ifdef IMEM_ALIGN_CHECK_EN
      checks++;
      if (mem_en !== 1'b0) begin
         errors++; $display("FAIL misalign_access got mem_en=%b exp 0", mem_en);
      end
      tick();
      fetch_req = 1'b0;
      checks++;
      if (fetch_valid !== 1'b1 || fetch_err !== 1'b1 || fetch_instr !== NOP) begin
         errors++; $display("FAIL misalign_resp got v=%b e=%b i=%h exp 1 1 %h", fetch_valid, fetch_err, fetch_instr, NOP);
      end
      last_instr = NOP;
`else
      checks++;
      if (mem_en !== 1'b1 || mem_addr !== 6'd1) begin
         errors++; $display("FAIL lowbits_access got en=%b a=%0d exp 1 1", mem_en, mem_addr);
      end
      tick();
      fetch_req = 1'b0;
      checks++;
      if (fetch_valid !== 1'b1 || fetch_err !== 1'b0 || fetch_instr !== ref_mem[1]) begin
         errors++; $display("FAIL lowbits_resp got v=%b e=%b i=%h exp 1 0 %h", fetch_valid, fetch_err, fetch_instr, ref_mem[1]);
      end
      last_instr = ref_mem[1];
`endif
      tick();
      checks++;
      if (fetch_valid !== 1'b0 || fetch_err !== 1'b0 || fetch_instr !== last_instr) begin
         errors++; $display("FAIL post_err_idle got v=%b e=%b i=%h exp 0 0 %h", fetch_valid, fetch_err, fetch_instr, last_instr);
      end
   endtask

   task automatic test_load_abort;
      fetch_req = 1'b1; fetch_addr = 32'hC;
      tick();
      load_start = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h0;
      checks++;
      if (fetch_valid !== 1'b1 || fetch_instr !== ref_mem[3]) begin
         errors++; $display("FAIL inflight_fetch got v=%b i=%h exp 1 %h", fetch_valid, fetch_instr, ref_mem[3]);
      end
      last_instr = ref_mem[3];
      #1;
      checks++;
      if (mem_en !== 1'b0) begin
         errors++; $display("FAIL load_wins_access got mem_en=%b exp 0", mem_en);
      end
      tick();
      load_start = 1'b0;
      checks++;
      if (fetch_valid !== 1'b0 || boot_done !== 1'b0 || load_ready !== 1'b1 || fetch_stall !== 1'b1) begin
         errors++; $display("FAIL load_wins got v=%b bd=%b lr=%b st=%b exp 0 0 1 1", fetch_valid, boot_done, load_ready, fetch_stall);
      end
      #1;
      checks++;
      if (mem_en !== 1'b0) begin
         errors++; $display("FAIL fetch_in_load got mem_en=%b exp 0", mem_en);
      end
      tick();
      fetch_req = 1'b0;
      checks++;
      if (fetch_valid !== 1'b0) begin
         errors++; $display("FAIL fetch_in_load_valid got %b exp 0", fetch_valid);
      end
      do_load(2, 1);   // start pulse is ignored while already in LOAD
      test_random_fetch(30);
   endtask

   task automatic test_reset_mid;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      load_valid = 1'b1; load_data = 32'hDEAD_BEEF;
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (mem_en !== 1'b0) begin
         errors++; $display("FAIL reset_gates_mem got mem_en=%b exp 0", mem_en);
      end
      tick();
      load_valid = 1'b0;
      checks++;
      if ({fetch_valid, fetch_instr, boot_done, fetch_err, load_ready, fetch_stall} !== {1'b0, 32'h0, 4'b0001}) begin
         errors++; $display("FAIL mid_load_reset got v=%b i=%h bd=%b er=%b lr=%b st=%b exp 0 0 0 0 0 1",
                            fetch_valid, fetch_instr, boot_done, fetch_err, load_ready, fetch_stall);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 6'd0 || mem_wdata !== 32'h0) begin
         errors++; $display("FAIL clear_restart got en=%b we=%b a=%0d d=%h exp 1 1 0 0", mem_en, mem_we, mem_addr, mem_wdata);
      end
      repeat (DEPTH + 2) tick();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      last_instr = '0;
      fetch_req = 1'b1; fetch_addr = 32'h8;
      #1;
      checks++;
      if (mem_en !== 1'b0) begin
         errors++; $display("FAIL idle_fetch_access got mem_en=%b exp 0", mem_en);
      end
      tick();
      fetch_req = 1'b0;
      checks++;
      if (fetch_valid !== 1'b0) begin
         errors++; $display("FAIL idle_fetch_valid got %b exp 0", fetch_valid);
      end
      do_load(1, 1);
      test_random_fetch(20);   // mostly cleared words plus the fresh word 0
      fetch_req = 1'b1; fetch_addr = 32'h0; rst = 1'b0;
      tick();
      fetch_req = 1'b0;
      checks++;
      if (fetch_valid !== 1'b0 || fetch_instr !== 32'h0) begin
         errors++; $display("FAIL reset_drops_fetch got v=%b i=%h exp 0 0", fetch_valid, fetch_instr);
      end
      rst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_load_fetch();
      test_full_load();
      test_wrap_align();
      test_load_abort();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
